// File: rtl/cache_manage_unit.sv
// cache_manage_unit: miss/refill controller between the CPU memory stage
// and a 2-way set-associative write-back cache array.
// Ports:
//   clk, rst (async, active-low)
//   cpu_*   : request in, stall/ready/load data out
//   cache_* : array addr/load/store/edit/ubhw/din out, registered status in
//   mem_*   : word bus, cs/we/addr/data out, data/ack in
//   hit_count_o / miss_count_o : wrapping statistics
module cache_manage_unit #(
  parameter int ADDR_BITS  = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_BITS-1:0] cpu_addr_i,
  input  logic [31:0]          cpu_din_i,
  input  logic [2:0]           cpu_ubhw_i,
  output logic                 cpu_stall_o,
  output logic                 cpu_ready_o,
  output logic [31:0]          cpu_dout_o,
  output logic [ADDR_BITS-1:0] cache_addr_o,
  output logic                 cache_load_o,
  output logic                 cache_store_o,
  output logic                 cache_edit_o,
  output logic [2:0]           cache_ubhw_o,
  output logic [31:0]          cache_din_o,
  input  logic                 cache_hit_i,
  input  logic                 cache_valid_i,
  input  logic                 cache_dirty_i,
  input  logic [22:0]          cache_tag_i,
  input  logic [31:0]          cache_dout_i,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
);

  localparam int BW    = $clog2(LINE_WORDS);
  localparam int OFF   = BW + 2;
  localparam int TAG_W = ADDR_BITS - 9;
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  localparam logic [2:0] UBHW_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    BACK_RD,
    BACK_WR,
    FILL
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BW-1:0]        beat_q;
  logic                 req_we_q;
  logic [ADDR_BITS-1:0] req_addr_q;
  logic [31:0]          req_din_q;
  logic [2:0]           req_ubhw_q;
  logic [TAG_W-1:0]     vtag_q;
  logic                 replay_q;
  logic                 wd_held_q;
  logic [31:0]          wdata_q;
  logic [31:0]          hit_q;
  logic [31:0]          miss_q;

  logic                 last_beat;
  logic [ADDR_BITS-1:0] line_addr;
  logic [ADDR_BITS-1:0] victim_addr;

  assign last_beat   = (beat_q == LAST);
  assign line_addr   = {req_addr_q[ADDR_BITS-1:OFF], beat_q, 2'b00};
  assign victim_addr = {vtag_q, req_addr_q[8:OFF], beat_q, 2'b00};

  assign cpu_stall_o  = (state_q != IDLE);
  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

  always_comb begin
    state_d       = state_q;
    cpu_ready_o   = 1'b0;
    cpu_dout_o    = '0;
    cache_addr_o  = '0;
    cache_load_o  = 1'b0;
    cache_store_o = 1'b0;
    cache_edit_o  = 1'b0;
    cache_ubhw_o  = '0;
    cache_din_o   = '0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        cache_addr_o = req_addr_q;
        cache_ubhw_o = req_ubhw_q;
        if (req_we_q) begin
          cache_edit_o = 1'b1;
          cache_din_o  = req_din_q;
        end else begin
          cache_load_o = 1'b1;
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (cache_hit_i) begin
          cpu_ready_o = 1'b1;
          if (!req_we_q) cpu_dout_o = cache_dout_i;
          state_d = IDLE;
        end else if (cache_valid_i && cache_dirty_i) begin
          state_d = BACK_RD;
        end else begin
          state_d = FILL;
        end
      end
      BACK_RD: begin
        // plain array read of the victim word, no LRU update
        cache_addr_o = line_addr;
        state_d      = BACK_WR;
      end
      BACK_WR: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = victim_addr;
        // array data is only valid in the first cycle; hold it after
        mem_data_o = wd_held_q ? wdata_q : cache_dout_i;
        if (mem_ack_i) state_d = last_beat ? FILL : BACK_RD;
      end
      FILL: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = line_addr;
        if (mem_ack_i) begin
          cache_store_o = 1'b1;
          cache_addr_o  = line_addr;
          cache_ubhw_o  = UBHW_WORD;
          cache_din_o   = mem_data_i;
          if (last_beat) state_d = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      req_we_q   <= 1'b0;
      req_addr_q <= '0;
      req_din_q  <= '0;
      req_ubhw_q <= '0;
      vtag_q     <= '0;
      replay_q   <= 1'b0;
      wd_held_q  <= 1'b0;
      wdata_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            req_we_q   <= cpu_we_i;
            req_addr_q <= cpu_addr_i;
            req_din_q  <= cpu_din_i;
            req_ubhw_q <= cpu_ubhw_i;
            replay_q   <= 1'b0;
          end
        end
        CHECK: begin
          if (cache_hit_i) begin
            if (!replay_q) hit_q <= hit_q + 32'd1;
          end else begin
            miss_q   <= miss_q + 32'd1;
            vtag_q   <= cache_tag_i;
            beat_q   <= '0;
            replay_q <= 1'b1;
          end
        end
        BACK_WR: begin
          if (mem_ack_i) begin
            // wraps to 0 after the last beat, ready for FILL
            beat_q    <= beat_q + BW'(1);
            wd_held_q <= 1'b0;
          end else if (!wd_held_q) begin
            wd_held_q <= 1'b1;
            wdata_q   <= cache_dout_i;
          end
        end
        FILL: begin
          if (mem_ack_i) beat_q <= beat_q + BW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_manage_unit.sv
// tb_cache_manage_unit: drives cache_manage_unit against a bench-side
// 2-way array and word memory, checked by a line-level reference model.
module tb_cache_manage_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_din_i = '0;
  logic [2:0]  cpu_ubhw_i = '0;
  logic        cpu_stall_o;
  logic        cpu_ready_o;
  logic [31:0] cpu_dout_o;
  logic [31:0] cache_addr_o;
  logic        cache_load_o;
  logic        cache_store_o;
  logic        cache_edit_o;
  logic [2:0]  cache_ubhw_o;
  logic [31:0] cache_din_o;
  logic        cache_hit_i = 1'b0;
  logic        cache_valid_i = 1'b0;
  logic        cache_dirty_i = 1'b0;
  logic [22:0] cache_tag_i = '0;
  logic [31:0] cache_dout_i = '0;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  always #5 clk = ~clk;

  cache_manage_unit dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_din_i(cpu_din_i),
    .cpu_ubhw_i(cpu_ubhw_i), .cpu_stall_o(cpu_stall_o),
    .cpu_ready_o(cpu_ready_o), .cpu_dout_o(cpu_dout_o),
    .cache_addr_o(cache_addr_o), .cache_load_o(cache_load_o),
    .cache_store_o(cache_store_o), .cache_edit_o(cache_edit_o),
    .cache_ubhw_o(cache_ubhw_o), .cache_din_o(cache_din_o),
    .cache_hit_i(cache_hit_i), .cache_valid_i(cache_valid_i),
    .cache_dirty_i(cache_dirty_i), .cache_tag_i(cache_tag_i),
    .cache_dout_i(cache_dout_i),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  int ack_d = 1;
  int cnt = 0;
  int rd_beats = 0;
  bit busy = 0;
  bit prev_cs = 0;
  bit prev_we = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  beat_t expq[$];

  logic [31:0] mem  [1024];
  logic [31:0] gold [1024];

  // reference: per set, most-recent and older resident line bases
  logic [31:0] r_new [32];
  logic [31:0] r_old [32];
  int          r_n   [32];
  bit          ldirty [int unsigned];

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_ext(input logic [31:0] wd,
      input logic [1:0] off, input logic [2:0] f);
    logic [7:0]  b;
    logic [15:0] h;
    b = wd[8*off +: 8];
    h = off[1] ? wd[31:16] : wd[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] wd,
      input logic [1:0] off, input logic [2:0] f, input logic [31:0] d);
    logic [31:0] r;
    r = wd;
    case (f)
      3'b000: r[8*off +: 8] = d[7:0];
      3'b001: if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // cache array model: registered status, LRU victim, hit updates LRU
  logic [22:0] atag  [32][2];
  bit          aval  [32][2];
  bit          adirty[32][2];
  bit          alru  [32];
  logic [31:0] adata [32][2][4];

  always @(posedge clk or negedge rst) begin : arr
    int s, w, hw, v;
    bit h;
    logic [22:0] t;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        alru[i] = 0;
        for (int k = 0; k < 2; k++) begin
          aval[i][k] = 0; adirty[i][k] = 0; atag[i][k] = '0;
        end
      end
      cache_hit_i <= 0; cache_valid_i <= 0; cache_dirty_i <= 0;
      cache_tag_i <= '0; cache_dout_i <= '0;
    end else begin
      s = int'(cache_addr_o[8:4]);
      w = int'(cache_addr_o[3:2]);
      t = cache_addr_o[31:9];
      h = 0; hw = 0;
      for (int k = 0; k < 2; k++)
        if (aval[s][k] && atag[s][k] == t) begin h = 1; hw = k; end
      v = int'(alru[s]);
      if (cache_load_o || cache_edit_o) begin
        cache_hit_i   <= h;
        cache_valid_i <= aval[s][v];
        cache_dirty_i <= adirty[s][v];
        cache_tag_i   <= atag[s][v];
        cache_dout_i  <= h ? ld_ext(adata[s][hw][w], cache_addr_o[1:0],
                                    cache_ubhw_o) : 32'h0BAD_0BAD;
        if (h) begin
          alru[s] = (hw == 0);
          if (cache_edit_o) begin
            adata[s][hw][w] = st_merge(adata[s][hw][w], cache_addr_o[1:0],
                                       cache_ubhw_o, cache_din_o);
            adirty[s][hw] = 1;
          end
        end
      end else if (cache_store_o) begin
        adata[s][v][w] = cache_din_o;
        atag[s][v] = t; aval[s][v] = 1; adirty[s][v] = 0;
        cache_hit_i <= 0;
      end else begin
        cache_hit_i  <= 0;
        cache_dout_i <= adata[s][v][w];
      end
    end
  end

  // memory responder plus per-cycle bus checks
  always @(negedge clk) begin : resp
    bit was;
    beat_t e;
    was = mem_ack_i;
    mem_ack_i = 0;
    mem_data_i = 32'hDEAD_BEEF;
    if (!rst) begin
      cnt = 0; prev_cs = 0;
    end else begin
      if (was) cnt = 0;
      if (mem_cs_o) begin
        if (prev_cs && !was) begin
          check("mem_addr_hold", mem_addr_o, prev_addr);
          check("mem_data_hold", mem_data_o, prev_data);
          check("mem_we_hold", 32'(mem_we_o), 32'(prev_we));
        end
        if (cnt == ack_d) begin
          mem_ack_i = 1;
          n_cmp++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: addr %h we %0d, none expected",
                     mem_addr_o, mem_we_o);
          end else begin
            e = expq.pop_front();
            check("beat_addr", mem_addr_o, e.addr);
            check("beat_we", 32'(mem_we_o), 32'(e.we));
            if (e.we) check("beat_wdata", mem_data_o, e.data);
          end
          if (mem_we_o) mem[mem_addr_o[11:2]] = mem_data_o;
          else begin
            mem_data_i = mem[mem_addr_o[11:2]];
            rd_beats++;
          end
        end else begin
          cnt++;
        end
      end
      n_cmp++;
      if (cpu_ready_o && !busy) begin
        n_fail++;
        $display("FAIL ready_when_idle: got 1 expected 0");
      end
      prev_cs = mem_cs_o; prev_we = mem_we_o;
      prev_addr = mem_addr_o; prev_data = mem_data_o;
    end
  end

  task automatic model_reset();
    expq.delete();
    ldirty.delete();
    for (int i = 0; i < 32; i++) r_n[i] = 0;
    for (int i = 0; i < 1024; i++) gold[i] = mem[i];
    exp_hit = 0;
    exp_miss = 0;
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr,
      input logic [31:0] din, input logic [2:0] f, input int d,
      input bit toggle, input int rst_beat,
      output logic [31:0] got, output int lat);
    logic [31:0] line, v, exp_dout;
    int s, exp_lat;
    bit hit, wb, done;
    beat_t e;
    line = addr & 32'hFFFF_FFF0;
    s = int'(addr[8:4]);
    hit = (r_n[s] > 0 && r_new[s] == line) ||
          (r_n[s] > 1 && r_old[s] == line);
    wb = 0;
    if (hit) begin
      exp_hit++;
      if (r_new[s] != line) begin r_old[s] = r_new[s]; r_new[s] = line; end
      exp_lat = 2;
    end else begin
      exp_miss++;
      if (r_n[s] == 2) begin
        v = r_old[s];
        if (ldirty.exists(v) && ldirty[v]) begin
          wb = 1;
          for (int k = 0; k < 4; k++) begin
            e.we = 1; e.addr = v + 32'(4*k);
            e.data = gold[v[11:2] + 10'(k)];
            expq.push_back(e);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        e.we = 0; e.addr = line + 32'(4*k); e.data = '0;
        expq.push_back(e);
      end
      if (r_n[s] > 0) r_old[s] = r_new[s];
      r_new[s] = line;
      if (r_n[s] < 2) r_n[s]++;
      ldirty[line] = 0;
      exp_lat = 2 + (wb ? 4 * (2 + d) : 0) + 4 * (d + 1) + 2;
    end
    exp_dout = '0;
    if (we) begin
      gold[addr[11:2]] = st_merge(gold[addr[11:2]], addr[1:0], f, din);
      ldirty[line] = 1;
    end else begin
      exp_dout = ld_ext(gold[addr[11:2]], addr[1:0], f);
    end

    ack_d = d;
    rd_beats = 0;
    got = '0;
    lat = 0;
    check("stall_before_req", 32'(cpu_stall_o), 0);
    cpu_req_i = 1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_din_i = din; cpu_ubhw_i = f;
    @(posedge clk);
    busy = 1;
    done = 0;
    while (!done && lat < 600) begin
      @(negedge clk); #1;
      lat++;
      if (toggle) begin
        cpu_req_i = lat[0];
        cpu_addr_i = addr ^ 32'h0000_0600 ^ 32'(lat);
        cpu_we_i = ~we;
        cpu_din_i = ~din;
      end else begin
        cpu_req_i = 0;
      end
      if (rst_beat >= 0 && rd_beats == rst_beat && mem_cs_o && !mem_we_o) begin
        #2 rst = 0;
        #1;
        check("rst_stall", 32'(cpu_stall_o), 0);
        check("rst_ready_dout", cpu_dout_o | 32'(cpu_ready_o), 0);
        check("rst_cache_addr", cache_addr_o, 0);
        check("rst_cache_ctl", {26'h0, cache_load_o, cache_store_o,
                                cache_edit_o, cache_ubhw_o}, 0);
        check("rst_cache_din", cache_din_o, 0);
        check("rst_mem_ctl", {30'h0, mem_cs_o, mem_we_o}, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_hits", hit_count_o, 0);
        check("rst_misses", miss_count_o, 0);
        busy = 0;
        cpu_req_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        return;
      end
      check("stall_busy", 32'(cpu_stall_o), 1);
      if (cpu_ready_o) begin
        done = 1;
        got = cpu_dout_o;
      end
    end
    busy = 0;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_din_i = '0;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: got no ready in %0d cycles expected %0d",
               lat, exp_lat);
      return;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (!we) check("load_data", got, exp_dout);
    @(posedge clk); #1;
    check("hit_count", hit_count_o, 32'(exp_hit));
    check("miss_count", miss_count_o, 32'(exp_miss));
    check("stall_after", 32'(cpu_stall_o), 0);
    check("beats_left", 32'(expq.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    int lat;
    logic [15:0] ii;
    for (int i = 0; i < 1024; i++) begin
      ii = 16'(i);
      mem[i] = {~ii, ii};
    end
    mem[64] = 32'h1000_00A0;
    mem[65] = 32'hCAFE_BEA1;
    mem[66] = 32'h1234_56F8;
    mem[67] = 32'h0BAD_F00D;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", 32'(cpu_stall_o), 0);
    check("reset_ready", 32'(cpu_ready_o), 0);
    check("reset_mem_cs", 32'(mem_cs_o), 0);
    check("reset_hits", hit_count_o, 0);
    check("reset_misses", miss_count_o, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk); #1;

    do_req(0, 32'h0000_0104, 0, 3'b010, 1, 0, -1, got, lat);
    check("cold_lw_lit", got, 32'hCAFE_BEA1);
    check("cold_lw_lat_lit", 32'(lat), 12);
    check("cold_miss_lit", miss_count_o, 1);

    do_req(0, 32'h0000_0109, 0, 3'b100, 1, 0, -1, got, lat);
    check("lbu_lit", got, 32'h0000_0056);
    check("lbu_lat_lit", 32'(lat), 2);
    check("lbu_hit_lit", hit_count_o, 1);

    do_req(1, 32'h0000_0104, 32'h0000_00AB, 3'b000, 1, 0, -1, got, lat);
    do_req(0, 32'h0000_0304, 0, 3'b010, 1, 0, -1, got, lat);
    do_req(0, 32'h0000_0504, 0, 3'b010, 1, 0, -1, got, lat);
    check("wb_mem_lit", mem[65], 32'hCAFE_BEAB);
    check("wb_lat_lit", 32'(lat), 24);

    do_req(0, 32'h0000_0708, 0, 3'b010, 5, 1, -1, got, lat);
    check("slow_lat_lit", 32'(lat), 28);

    do_req(0, 32'h0000_020A, 0, 3'b001, 0, 0, -1, got, lat);
    check("lh_sign_lit", got, 32'hFFFF_FF7D);
    do_req(1, 32'h0000_0A06, 32'h1234_BEEF, 3'b001, 0, 0, -1, got, lat);
    do_req(0, 32'h0000_0000, 0, 3'b010, 0, 0, -1, got, lat);
    do_req(0, 32'h0000_0E00, 0, 3'b010, 0, 0, -1, got, lat);
    check("wb0_lat_lit", 32'(lat), 16);
    do_req(0, 32'h0000_0A06, 0, 3'b101, 2, 0, -1, got, lat);
    check("lhu_lit", got, 32'h0000_BEEF);

    do_req(0, 32'h0000_00C0, 0, 3'b010, 2, 0, 2, got, lat);
    @(negedge clk); #1;
    do_req(0, 32'h0000_0104, 0, 3'b010, 1, 0, -1, got, lat);
    check("post_rst_lw_lit", got, 32'hCAFE_BEAB);
    check("post_rst_miss_lit", miss_count_o, 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_manage_unit.md
Name: cache_manage_unit

Overview:
- Controller FSM between the CPU memory stage and the 2-way set-associative cache storage array.
- On the CPU side it accepts one load/store request at a time and stalls the CPU until the request completes.
- On the cache side it drives the array's addr/load/store/edit/u_b_h_w/din inputs and consumes its registered hit/dout/valid/dirty/tag outputs.
- On a miss it writes back a dirty victim line and refills the line word-by-word over a simple request/ack memory bus, then replays the access so that it hits.

Parameters:
- ADDR_BITS, 32, address width.
- LINE_WORDS, 4, words per cache line; the beat counter is log2(LINE_WORDS) bits.
- Address split is fixed: tag [31:9], index [8:4], word [3:2], byte [1:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req_i  in  1  request valid, level
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address
- cpu_din_i  in  32  store data
- cpu_ubhw_i  in  3  width/sign select, RV32I LB/LH/LW/LBU/LHU encoding
- cpu_stall_o  out  1  CPU must hold the pipeline
- cpu_ready_o  out  1  one-cycle completion pulse
- cpu_dout_o  out  32  load data, valid while cpu_ready_o=1
- cache_addr_o  out  32  cache array address
- cache_load_o, cache_store_o, cache_edit_o  out  1 each  array control
- cache_ubhw_o  out  3  array width select
- cache_din_o  out  32  array write data
- cache_hit_i, cache_valid_i, cache_dirty_i  in  1 each  registered array status
- cache_tag_i  in  23  registered victim tag
- cache_dout_i  in  32  registered array data
- mem_cs_o, mem_we_o  out  1 each  memory request and write enable
- mem_addr_o  out  32  word-aligned memory address
- mem_data_o  out  32  memory write data
- mem_data_i  in  32  memory read data
- mem_ack_i  in  1  one-cycle beat-complete pulse
- hit_count_o, miss_count_o  out  32 each  statistics, wrap at 2^32

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; beat counter, latched request and victim tag cleared; every output 0; both counters 0; any in-flight memory beat is abandoned.
- cpu_stall_o = (state != IDLE). The request is latched only in IDLE when cpu_req_i=1; cpu_req_i is ignored while busy.
- IDLE -> LOOKUP on accept.
- LOOKUP (1 cycle):
  - cache_addr_o = latched address; cache_ubhw_o = latched width.
  - Load: cache_load_o=1. Store: cache_edit_o=1 and cache_din_o = store data.
  - Go to CHECK.
- CHECK reads the registered cache status:
  - cache_hit_i=1: cpu_ready_o=1; on a load, cpu_dout_o = cache_dout_i; hit_count_o +1 (first lookup only); go to IDLE.
  - Miss: miss_count_o +1; latch cache_tag_i as the victim tag; if cache_valid_i & cache_dirty_i go to BACK_RD with beat=0, else go to FILL with beat=0.
  - A replayed lookup that hits returns ready but does not increment hit_count_o.
- BACK_RD (1 cycle): cache_addr_o = {req_index line, beat, 00}, cache_load_o=0 (victim word read, no LRU update). Go to BACK_WR.
- BACK_WR:
  - Hold mem_cs_o=1, mem_we_o=1, mem_addr_o = {victim_tag, index, beat, 00}, mem_data_o = cache_dout_i.
  - Address and data are latched, so they stay stable until mem_ack_i.
  - On ack: if beat=LINE_WORDS-1, go to FILL with beat=0; else beat+1 and go to BACK_RD.
- FILL:
  - Hold mem_cs_o=1, mem_we_o=0, mem_addr_o = {req_tag, index, beat, 00}.
  - On the ack cycle: cache_store_o=1, cache_addr_o = the same address, cache_din_o = mem_data_i.
  - On the last beat go to LOOKUP (replay); otherwise beat+1.
- mem_ack_i outside BACK_WR/FILL is ignored.
- Memory outputs stay stable for any ack latency, including 0 wait states (ack in the first cycle of cs).
- Hit latency is 2 cycles from accept to cpu_ready_o.
- Miss latency is 2 + (dirty ? LINE_WORDS*(1+ackdelay+1) : 0) + LINE_WORDS*(ackdelay+1) + 2 cycles.
- Control pulses are asserted only in their named states and are 0 everywhere else.

Test Plan:
- Cold load LW 0x0000_0104 with memory 0x100..0x10C = A0..A3 and ack 1 cycle after cs: 4 read beats at 0x100, 0x104, 0x108, 0x10C, no write beats, then cpu_ready_o=1 with cpu_dout_o=A1; miss_count=1.
- LBU 0x0000_0109 right after (A2=0x1234_56F8): no mem_cs_o; ready 2 cycles after accept; dout=0x0000_0056; hit_count=1.
- SB 0x0000_0104 din=0xAB, then LW 0x304, then LW 0x504 (same index):
  - The SB is a hit; the LW 0x304 fills the other way.
  - The LW 0x504 writes back 4 beats to 0x100..0x10C, with the beat at 0x104 = {A1[31:8], AB}, then fills 0x500..0x50C.
- mem_ack_i delayed 5 cycles per beat: mem_addr_o/mem_data_o/mem_cs_o held constant, cpu_stall_o=1 throughout, beat count exactly 4.
- rst pulled low during the third FILL beat: all outputs 0 in the same cycle with no clock edge; after release, LW 0x104 restarts a full miss sequence.
- cpu_req_i toggled and cpu_addr_i changed while stalled: no effect; completion reflects the originally latched request.
